// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the MEM-stage data-memory port: CPU-first with DMA ageing,
// bounded DMA lock bursts, and a one-cycle CPU priority window after every burst.
module data_bus_arbiter #(
  parameter int AGE_MAX  = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // NORMAL | CPU priority; DMA wins when CPU idle, aged out, or CPU absent in cool cycle
  // LOCKED | DMA owns the bus while it holds dma_req & dma_lock, up to LOCK_MAX cycles
  typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} mode_t;

  localparam logic [3:0] AGE_TOP  = 4'(AGE_MAX);
  localparam logic [7:0] LOCK_TOP = 8'(LOCK_MAX);

  mode_t      mode, mode_nxt;
  logic [3:0] age, age_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       cool, cool_nxt;
  logic       cpu_win, dma_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode     <= NORMAL;
      age      <= '0;
      lock_cnt <= '0;
      cool     <= 1'b0;
    end else begin
      mode     <= mode_nxt;
      age      <= age_nxt;
      lock_cnt <= lock_cnt_nxt;
      cool     <= cool_nxt;
    end
  end

  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (mode == LOCKED) begin
      dma_win = dma_req;
      cpu_win = cpu_req & ~dma_req;
    end else if (cool) begin
      cpu_win = cpu_req;
      dma_win = dma_req & ~cpu_req;
    end else begin
      dma_win = dma_req & (~cpu_req | (age == AGE_TOP));
      cpu_win = cpu_req & ~dma_win;
    end
  end

  always_comb begin
    mode_nxt     = mode;
    lock_cnt_nxt = lock_cnt;
    cool_nxt     = 1'b0;
    age_nxt      = age;
    if (dma_win || !dma_req) begin
      age_nxt = '0;
    end else if (cpu_win && age < AGE_TOP) begin
      age_nxt = age + 4'd1;
    end
    if (mode == LOCKED) begin
      if (!dma_req || !dma_lock || (dma_win && lock_cnt == LOCK_TOP)) begin
        mode_nxt     = NORMAL;
        lock_cnt_nxt = '0;
        cool_nxt     = 1'b1;
      end else if (dma_win && dma_lock) begin
        lock_cnt_nxt = lock_cnt + 8'd1;
      end
    end else if (dma_win && dma_lock && !cool) begin
      mode_nxt     = LOCKED;
      lock_cnt_nxt = 8'd1;
    end
  end

  // Outputs are held at zero for the whole time reset is low, not just after an edge.
  always_comb begin
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    dma_rdata = '0;
    if (reset) begin
      cpu_stall = cpu_req & ~cpu_win;
      dma_gnt   = dma_win;
      if (dma_win) begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_read  = ~dma_we;
        mem_write = dma_we;
        dma_rdata = dma_we ? 32'd0 : mem_rdata;
      end else if (cpu_win) begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = ~cpu_we;
        mem_write = cpu_we;
        cpu_rdata = cpu_we ? 32'd0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration rules and a reference memory.
module tb_data_bus_arbiter;
  localparam int AGE_MAX  = 4;
  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  bit          mem_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: lock burst in progress, CPU-first window, consecutive DMA losses, locked cycles served
  bit m_locked, m_cpu_first;
  int m_losses, m_served;

  data_bus_arbiter #(.AGE_MAX(AGE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_val(int i);
    return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01000193) ^ 32'h5A5A0000);
  endfunction

  assign mem_rdata = mem_arr[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= seed_val(i);
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  wire [131:0] obs = {cpu_stall, dma_gnt, mem_read, mem_write, mem_addr, mem_wdata, cpu_rdata, dma_rdata};

  function automatic void model_reset();
    m_locked = 0; m_cpu_first = 0; m_losses = 0; m_served = 0;
  endfunction

  // 0 = nobody, 1 = CPU, 2 = DMA
  function automatic int winner();
    if (!reset) return 0;
    if (m_locked) return dma_req ? 2 : (cpu_req ? 1 : 0);
    if (m_cpu_first) return cpu_req ? 1 : (dma_req ? 2 : 0);
    if (dma_req && (!cpu_req || m_losses >= AGE_MAX)) return 2;
    return cpu_req ? 1 : 0;
  endfunction

  function automatic logic [131:0] expect_vec();
    int w = winner();
    logic stall = reset && cpu_req && (w != 1);
    logic gnt = (w == 2);
    logic rd = 0, wr = 0;
    logic [31:0] a = 0, wd = 0, cr = 0, dr = 0;
    if (w == 1) begin
      a = cpu_addr; wd = cpu_wdata; rd = !cpu_we; wr = cpu_we;
      if (!cpu_we) cr = ref_mem[cpu_addr[9:2]];
    end else if (w == 2) begin
      a = dma_addr; wd = dma_wdata; rd = !dma_we; wr = dma_we;
      if (!dma_we) dr = ref_mem[dma_addr[9:2]];
    end
    return {stall, gnt, rd, wr, a, wd, cr, dr};
  endfunction

  function automatic void model_advance();
    int w = winner();
    if (!reset) begin
      model_reset();
      return;
    end
    if (w == 1 && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
    if (w == 2 && dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
    if (w == 2 || !dma_req) m_losses = 0;
    else if (m_losses < AGE_MAX) m_losses++;
    if (m_locked) begin
      m_served++;
      m_cpu_first = 0;
      if (!dma_req || !dma_lock || m_served >= LOCK_MAX) begin
        m_locked = 0;
        m_cpu_first = 1;
      end
    end else begin
      if (w == 2 && dma_lock && !m_cpu_first) begin
        m_locked = 1;
        m_served = 0;
      end
      m_cpu_first = 0;
    end
  endfunction

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    cpu_req = 0; dma_req = 0; dma_lock = 0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] rand_addr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  task automatic test_reset();
    logic [131:0] e;
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = $urandom;
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h48; dma_wdata = $urandom;
    #2;
    n_cmp++;
    if (obs !== 132'd0) begin n_bad++; $display("FAIL reset_outputs_zero: got %h want 0", obs); end
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 132'd0) begin n_bad++; $display("FAIL reset_held_edge: got %h want 0", obs); end
    reset = 1; model_reset();
    cpu_we = 0; dma_we = 0;
    #1;
    n_cmp++;
    if ({cpu_stall, dma_gnt} !== 2'b00) begin
      n_bad++; $display("FAIL reset_release_cpu_first: stall/gnt got %b want 00", {cpu_stall, dma_gnt});
    end
    e = expect_vec(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_release_model: got %h want %h", obs, e); end
    step();
  endtask

  task automatic test_cpu_read();
    logic [131:0] e;
    idle(2);
    cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 32'h0; dma_we = 0;
    #1;
    n_cmp++;
    if (obs !== 132'd0) begin n_bad++; $display("FAIL both_idle: got %h want 0", obs); end
    cpu_req = 1;
    #1;
    n_cmp++;
    if ({cpu_rdata, cpu_stall, mem_read, dma_gnt} !== {32'hDEADBEEF, 3'b010}) begin
      n_bad++; $display("FAIL cpu_read_0x10: rdata %h stall %b rd %b gnt %b want DEADBEEF 0 1 0",
                        cpu_rdata, cpu_stall, mem_read, dma_gnt);
    end
    e = expect_vec(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL cpu_read_model: got %h want %h", obs, e); end
    step();
  endtask

  task automatic test_ageing();
    logic [131:0] e;
    idle(2);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_we = 0; dma_lock = 0; dma_addr = 32'h80;
    for (int i = 0; i < 15; i++) begin
      #1;
      n_cmp++;
      if ({dma_gnt, cpu_stall} !== {2{(i % 5) == 4}}) begin
        n_bad++; $display("FAIL ageing cyc %0d: gnt/stall got %b want %b", i, {dma_gnt, cpu_stall}, {2{(i % 5) == 4}});
      end
      e = expect_vec(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL ageing_model cyc %0d: got %h want %h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_lock_burst();
    logic [131:0] e;
    logic want;
    idle(2);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h04;
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h08; dma_wdata = $urandom;
    // four aged CPU wins, entry grant at 4, 16 locked grants 5..20, cool CPU cycle 21
    for (int i = 0; i < 25; i++) begin
      want = (i >= 4) && (i <= 4 + LOCK_MAX);
      #1;
      n_cmp++;
      if (dma_gnt !== want) begin n_bad++; $display("FAIL lock_burst cyc %0d: gnt got %b want %b", i, dma_gnt, want); end
      e = expect_vec(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL lock_burst_model cyc %0d: got %h want %h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_write_then_read();
    logic [131:0] e;
    idle(2);
    dma_req = 1; dma_we = 1; dma_lock = 0; dma_addr = 32'h20; dma_wdata = 32'h12345678;
    #1;
    n_cmp++;
    if ({mem_write, mem_read, dma_gnt, mem_addr, mem_wdata} !== {3'b101, 32'h20, 32'h12345678}) begin
      n_bad++; $display("FAIL dma_write: wr %b rd %b gnt %b addr %h data %h want 1 0 1 20 12345678",
                        mem_write, mem_read, dma_gnt, mem_addr, mem_wdata);
    end
    e = expect_vec(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL dma_write_model: got %h want %h", obs, e); end
    step();
    dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    #1;
    n_cmp++;
    if (cpu_rdata !== 32'h12345678) begin n_bad++; $display("FAIL cpu_readback: got %h want 12345678", cpu_rdata); end
    e = expect_vec(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL cpu_readback_model: got %h want %h", obs, e); end
    step();
  endtask

  task automatic test_lock_drop();
    logic [131:0] e;
    logic [1:0] want;
    idle(2);
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h0C;
    dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      if (i >= 1) cpu_req = 1;
      if (i >= 3) dma_lock = 0;
      want = (i < 4) ? {1'b1, cpu_req} : 2'b00;
      #1;
      n_cmp++;
      if ({dma_gnt, cpu_stall} !== want) begin
        n_bad++; $display("FAIL lock_drop cyc %0d: gnt/stall got %b want %b", i, {dma_gnt, cpu_stall}, want);
      end
      e = expect_vec(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL lock_drop_model cyc %0d: got %h want %h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [131:0] e;
    logic [31:0] first_data;
    idle(2);
    first_data = $urandom;
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h30;
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h30; dma_wdata = first_data;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) cpu_req = 1;
      #1;
      e = expect_vec(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL midlock_burst cyc %0d: got %h want %h", i, obs, e); end
      step();
    end
    dma_wdata = first_data ^ 32'hFFFF_0000;
    #1;
    reset = 0; model_reset();
    #1;
    n_cmp++;
    if (obs !== 132'd0) begin n_bad++; $display("FAIL midlock_reset_zero: got %h want 0", obs); end
    step();
    reset = 1;
    #1;
    n_cmp++;
    if ({cpu_stall, dma_gnt, cpu_rdata} !== {2'b00, first_data}) begin
      n_bad++; $display("FAIL midlock_resume: stall %b gnt %b rdata %h want 0 0 %h", cpu_stall, dma_gnt, cpu_rdata, first_data);
    end
    e = expect_vec(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL midlock_resume_model: got %h want %h", obs, e); end
    step();
  endtask

  task automatic test_random();
    logic [131:0] e;
    bit hold = 0;
    bit bursty;
    idle(2);
    for (int i = 0; i < 600; i++) begin
      bursty = ((i / 100) % 2) == 1;
      if (!hold) begin
        cpu_req = ($urandom_range(0, 99) < 55);
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr();
        cpu_wdata = $urandom;
      end
      dma_req = ($urandom_range(0, 99) < (bursty ? 95 : 50));
      dma_lock = ($urandom_range(0, 99) < (bursty ? 95 : 30));
      dma_we = 1'($urandom_range(0, 1));
      dma_addr = rand_addr();
      dma_wdata = $urandom;
      #1;
      e = expect_vec(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL random cyc %0d: got %h want %h", i, obs, e); end
      hold = cpu_req && (winner() != 1);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
    model_reset();
    test_reset();
    test_cpu_read();
    test_ageing();
    test_lock_burst();
    test_write_then_read();
    test_lock_drop();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
